// File: rtl/microwave_pkg.sv
// Shared types for the microwave cook timer: FSM states, BCD digits, MM:SS time.
package microwave_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t min_tens;
        bcd_t min_ones;
        bcd_t sec_tens;
        bcd_t sec_ones;
    } mmss_t;

    localparam mmss_t TIME_ZERO = '0;

    function automatic logic is_legal_digit(input bcd_t d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/bcd_time_dec.sv
// Combinational one-second decrement of a BCD MM:SS value with borrow, plus zero detects.
module bcd_time_dec
    import microwave_pkg::*;
(
    input  mmss_t cur,
    output mmss_t dec_time,
    output logic  cur_zero,
    output logic  dec_zero
);

    // Seconds are only borrowed from in BCD, so entered values above 59 count down naturally.
    always_comb begin
        dec_time = cur;
        if (cur.sec_ones != 4'd0) begin
            dec_time.sec_ones = cur.sec_ones - 4'd1;
        end else if (cur.sec_tens != 4'd0) begin
            dec_time.sec_tens = cur.sec_tens - 4'd1;
            dec_time.sec_ones = 4'd9;
        end else if ((cur.min_ones != 4'd0) || (cur.min_tens != 4'd0)) begin
            dec_time.sec_tens = 4'd5;
            dec_time.sec_ones = 4'd9;
            if (cur.min_ones != 4'd0) begin
                dec_time.min_ones = cur.min_ones - 4'd1;
            end else begin
                dec_time.min_ones = 4'd9;
                dec_time.min_tens = cur.min_tens - 4'd1;
            end
        end
    end

    assign cur_zero = (cur == TIME_ZERO);
    assign dec_zero = (dec_time == TIME_ZERO);

endmodule

// File: rtl/cook_timer.sv
// Microwave countdown timer: BCD keypad entry, per-second countdown, magnetron enable, done flag.
// Optional completion beeper enabled by defining COOK_TIMER_BEEP_EN.
module cook_timer
    import microwave_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int BEEP_SECS     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       S,
    input  logic       R,
    input  logic       clear,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mag_on,
    output logic       timer_done,
    output logic       beep
);

    localparam int PRE_W = $clog2(TICKS_PER_SEC);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICKS_PER_SEC - 1);

    if (TICKS_PER_SEC < 2 || BEEP_SECS < 1) begin : g_bad_params
        $error("cook_timer: TICKS_PER_SEC must be >= 2 and BEEP_SECS >= 1");
    end

    state_t           state;
    mmss_t            cur_time;
    mmss_t            dec_time;
    mmss_t            shifted_time;
    mmss_t            loaded_time;
    logic [PRE_W-1:0] prescaler;
    logic             time_zero;
    logic             dec_zero;
    logic             tick;
    logic             digit_ok;

    bcd_time_dec u_dec (
        .cur      (cur_time),
        .dec_time (dec_time),
        .cur_zero (time_zero),
        .dec_zero (dec_zero)
    );

    assign tick         = (prescaler == PRE_MAX);
    assign digit_ok     = digit_valid && is_legal_digit(digit);
    assign shifted_time = {cur_time.min_ones, cur_time.sec_tens, cur_time.sec_ones, digit};
    assign loaded_time  = {12'h000, digit};

    assign min_tens = cur_time.min_tens;
    assign min_ones = cur_time.min_ones;
    assign sec_tens = cur_time.sec_tens;
    assign sec_ones = cur_time.sec_ones;

    // Pause keeps the prescaler, so a resumed run finishes the partial second it was in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cur_time   <= TIME_ZERO;
            prescaler  <= '0;
            mag_on     <= 1'b0;
            timer_done <= 1'b0;
        end else if (clear) begin
            state      <= IDLE;
            cur_time   <= TIME_ZERO;
            prescaler  <= '0;
            mag_on     <= 1'b0;
            timer_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (S && !R && !time_zero) begin
                        state     <= RUNNING;
                        prescaler <= '0;
                        mag_on    <= 1'b1;
                    end else if (digit_ok) begin
                        cur_time <= shifted_time;
                    end
                end
                RUNNING: begin
                    if (R) begin
                        state  <= PAUSED;
                        mag_on <= 1'b0;
                    end else if (tick) begin
                        prescaler <= '0;
                        cur_time  <= dec_time;
                        if (dec_zero) begin
                            state      <= DONE;
                            mag_on     <= 1'b0;
                            timer_done <= 1'b1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                PAUSED: begin
                    if (S && !R) begin
                        state  <= RUNNING;
                        mag_on <= 1'b1;
                    end
                end
                DONE: begin
                    if (digit_ok) begin
                        state      <= IDLE;
                        cur_time   <= loaded_time;
                        prescaler  <= '0;
                        timer_done <= 1'b0;
                    end
`ifdef COOK_TIMER_BEEP_EN
                    else begin
                        prescaler <= tick ? '0 : prescaler + 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COOK_TIMER_BEEP_EN
    localparam int BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    logic              done_entry;
    logic              beep_q;
    logic [BEEP_W-1:0] beep_secs_left;

    assign done_entry = (state == RUNNING) && !R && tick && dec_zero;

    // Beep length counts whole prescaler seconds; DONE entry restarts the prescaler at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_q         <= 1'b0;
            beep_secs_left <= '0;
        end else if (clear) begin
            beep_q         <= 1'b0;
            beep_secs_left <= '0;
        end else if (done_entry) begin
            beep_q         <= 1'b1;
            beep_secs_left <= BEEP_W'(BEEP_SECS - 1);
        end else if (state != DONE || digit_ok) begin
            beep_q <= 1'b0;
        end else if (beep_q && tick) begin
            if (beep_secs_left == '0) begin
                beep_q <= 1'b0;
            end else begin
                beep_secs_left <= beep_secs_left - 1'b1;
            end
        end
    end

    assign beep = beep_q;
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with a scoreboard fed by a seconds-based reference model.
module tb_cook_timer;

    localparam int T  = 4;
    localparam int BS = 3;
`ifdef COOK_TIMER_BEEP_EN
    localparam bit BEEP_EN = 1'b1;
`else
    localparam bit BEEP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       S = 1'b0;
    logic       R = 1'b0;
    logic       clear = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       mag_on, timer_done, beep;

    cook_timer #(.TICKS_PER_SEC(T), .BEEP_SECS(BS)) dut (
        .clk         (clk),
        .rst         (rst),
        .S           (S),
        .R           (R),
        .clear       (clear),
        .digit_valid (digit_valid),
        .digit       (digit),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .mag_on      (mag_on),
        .timer_done  (timer_done),
        .beep        (beep)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mstate_e;
    typedef struct {
        string       tag;
        logic [18:0] val;
    } exp_s;

    mstate_e m_state;
    int      m_min, m_sec, m_pre, m_bleft;
    bit      m_mag, m_done, m_beep;
    exp_s    sb[$];
    int      passes = 0;
    int      checks = 0;
    int      fails  = 0;
    int      bcount;

    function automatic logic [18:0] obsVec();
        return {min_tens, min_ones, sec_tens, sec_ones, mag_on, timer_done, beep};
    endfunction

    function automatic logic [18:0] modelVec();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10), m_mag, m_done, m_beep};
    endfunction

    task automatic modelReset();
        m_state = M_IDLE;
        m_min = 0; m_sec = 0; m_pre = 0; m_bleft = 0;
        m_mag = 1'b0; m_done = 1'b0; m_beep = 1'b0;
    endtask

    // Reference keeps minutes and seconds as integers rather than BCD digits.
    task automatic modelStep(input bit s, input bit r, input bit c, input bit dv, input logic [3:0] d);
        bit legal;
        legal = dv && (d <= 4'd9);
        if (c) begin
            modelReset();
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (s && !r && (m_min + m_sec) != 0) begin
                        m_state = M_RUN; m_pre = 0; m_mag = 1'b1;
                    end else if (legal) begin
                        int mo, st, so;
                        mo = m_min % 10; st = m_sec / 10; so = m_sec % 10;
                        m_min = mo * 10 + st;
                        m_sec = so * 10 + int'(d);
                    end
                end
                M_RUN: begin
                    if (r) begin
                        m_state = M_PAUSE; m_mag = 1'b0;
                    end else begin
                        m_pre++;
                        if (m_pre == T) begin
                            m_pre = 0;
                            if (m_sec > 0) m_sec--;
                            else begin m_sec = 59; m_min--; end
                            if (m_min == 0 && m_sec == 0) begin
                                m_state = M_DONE; m_mag = 1'b0; m_done = 1'b1;
                                if (BEEP_EN) begin m_beep = 1'b1; m_bleft = BS * T; end
                            end
                        end
                    end
                end
                M_PAUSE: begin
                    if (s && !r) begin m_state = M_RUN; m_mag = 1'b1; end
                end
                M_DONE: begin
                    if (legal) begin
                        m_min = 0; m_sec = int'(d); m_state = M_IDLE;
                        m_done = 1'b0; m_beep = 1'b0; m_bleft = 0;
                    end else if (m_bleft > 0) begin
                        m_bleft--;
                        m_beep = (m_bleft > 0);
                    end
                end
                default: m_state = M_IDLE;
            endcase
        end
    endtask

    task automatic compare(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        exp_s e;
        e = sb.pop_front();
        compare(e.tag, obsVec(), e.val);
    endtask

    task automatic applyStimulus(input string tag, input bit s, input bit r, input bit c,
                                 input bit dv, input logic [3:0] d);
        S = s; R = r; clear = c; digit_valid = dv; digit = d;
        modelStep(s, r, c, dv, d);
        sb.push_back('{tag, modelVec()});
        @(posedge clk);
        #1;
        S = 1'b0; R = 1'b0; clear = 1'b0; digit_valid = 1'b0; digit = 4'd0;
        checkOutput();
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic key(input logic [3:0] d);
        applyStimulus("key", 1'b0, 1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic constCheck(input string tag, input logic [15:0] t, input bit mag, input bit done);
        compare(tag, {1'b0, min_tens, min_ones, sec_tens, sec_ones, mag_on, timer_done},
                {1'b0, t, mag, done});
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        compare("reset_state", obsVec(), 19'd0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Entry and first decrement
        key(4'd1); key(4'd3); key(4'd0);
        constCheck("entry_0130", 16'h0130, 1'b0, 1'b0);
        applyStimulus("start", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        constCheck("mag_on_start", 16'h0130, 1'b1, 1'b0);
        idle("run", T);
        constCheck("first_dec_0129", 16'h0129, 1'b1, 1'b0);
        applyStimulus("clear_run", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        constCheck("clear_running", 16'h0000, 1'b0, 1'b0);

        // Minute borrow and seconds above 59
        key(4'd1); key(4'd0); key(4'd0);
        applyStimulus("start", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle("borrow", T);
        constCheck("borrow_0059", 16'h0059, 1'b1, 1'b0);
        applyStimulus("clear", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        key(4'd7); key(4'd5);
        applyStimulus("start", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle("over59", T);
        constCheck("dec_0074", 16'h0074, 1'b1, 1'b0);
        idle("over59", 4 * T);
        constCheck("dec_0070", 16'h0070, 1'b1, 1'b0);
        idle("over59", T);
        constCheck("dec_0069", 16'h0069, 1'b1, 1'b0);
        applyStimulus("clear", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Completion, ignored S/R in DONE, beep length, exit by digit
        key(4'd2);
        applyStimulus("start", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle("finish", T);
        constCheck("dec_0001", 16'h0001, 1'b1, 1'b0);
        idle("finish", T);
        constCheck("done_0000", 16'h0000, 1'b0, 1'b1);
        bcount = int'(beep);
        applyStimulus("done_S", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        bcount += int'(beep);
        applyStimulus("done_R", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        bcount += int'(beep);
        applyStimulus("done_SR", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        bcount += int'(beep);
        constCheck("done_hold", 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            applyStimulus("beep", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
            bcount += int'(beep);
        end
        compare("beep_cycles", 19'(bcount), BEEP_EN ? 19'd12 : 19'd0);
        key(4'd5);
        constCheck("done_exit_0005", 16'h0005, 1'b0, 1'b0);
        applyStimulus("clear", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Pause and resume keeps partial second
        key(4'd1); key(4'd0);
        applyStimulus("start", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle("pre", 2);
        applyStimulus("pause", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        constCheck("paused_0010", 16'h0010, 1'b0, 1'b0);
        idle("paused", 3);
        key(4'd3);
        applyStimulus("pause_SR", 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        constCheck("paused_SR", 16'h0010, 1'b0, 1'b0);
        applyStimulus("resume", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        constCheck("resumed", 16'h0010, 1'b1, 1'b0);
        idle("resume", 1);
        constCheck("resume_no_dec", 16'h0010, 1'b1, 1'b0);
        idle("resume", 1);
        constCheck("resume_dec_0009", 16'h0009, 1'b1, 1'b0);
        applyStimulus("clear", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

        // Illegal inputs in IDLE
        applyStimulus("start_zero", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        constCheck("start_zero_idle", 16'h0000, 1'b0, 1'b0);
        key(4'd4);
        key(4'hC);
        constCheck("illegal_digit", 16'h0004, 1'b0, 1'b0);

        // Asynchronous reset mid-run
        applyStimulus("start", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        idle("pre_rst", 2);
        #2 rst = 1'b1;
        #1;
        compare("async_reset", obsVec(), 19'd0);
        modelReset();
        @(posedge clk);
        #1 rst = 1'b0;
        idle("post_rst", 2);

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cook_timer.md
Name: cook_timer

Overview:
- Countdown timer stage feeding the microwave control logic.
- Accepts keypad digit entry as 4-digit BCD MM:SS; runs on the set/reset pulses produced by the control logic; counts down once per second while cooking.
- Drives magnetron enable and the `timer_done` flag consumed by the control logic.

Parameters:
- TICKS_PER_SEC, 50000000, clock cycles per one-second decrement (minimum 2)
- BEEP_SECS, 3, seconds of beep after completion (used only with the optional feature)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- S  input  1  start request from control logic (level, sampled each cycle)
- R  input  1  stop request from control logic (level, sampled each cycle)
- clear  input  1  synchronous clear of entered time (keypad clear)
- digit_valid  input  1  one-cycle strobe, keypad digit present
- digit  input  4  keypad digit, BCD
- min_tens, min_ones, sec_tens, sec_ones  output  4 each  displayed time, BCD
- mag_on  output  1  magnetron enable
- timer_done  output  1  countdown reached 00:00
- beep  output  1  completion beeper

Behaviour:
- Clock and reset: one clock, `clk`. `rst` is asynchronous and active-high; all flops clear immediately on assertion.
- Reset values: state IDLE, all digits 0, prescaler 0, `mag_on`=0, `timer_done`=0, `beep`=0.
- States: IDLE, RUNNING, PAUSED, DONE. All outputs are registered.
- Per-cycle priority: `rst` > `clear` > `R` > `S` > `digit_valid`.
- `clear` (any state): digits := 0000, state := IDLE, `mag_on`=0, `timer_done`=0.
- IDLE:
  - `digit_valid` with `digit`<=9: shift left. `min_tens`:=`min_ones`, `min_ones`:=`sec_tens`, `sec_tens`:=`sec_ones`, `sec_ones`:=`digit`. Old `min_tens` is discarded.
  - `digit`>9 is ignored.
  - `S`=1, `R`=0 and time != 0000: RUNNING next cycle, prescaler := 0, `mag_on`=1 from that cycle.
  - `S` with time 0000 is ignored.
- RUNNING:
  - Prescaler increments each cycle.
  - When prescaler == TICKS_PER_SEC-1: prescaler := 0 and the time decrements by one second.
  - First decrement is visible TICKS_PER_SEC cycles after RUNNING is entered.
  - Decrement rules:
    - `sec_ones`>0: decrement it.
    - Else `sec_tens`>0: `sec_tens`-1, `sec_ones`=9.
    - Else (seconds 00, minutes nonzero): seconds := 59, minutes decrement with the same BCD borrow (`min_ones` 0 -> 9, `min_tens`-1).
  - Entered seconds above 59 (e.g. 0:75) count down naturally through 70, 69, and so on.
  - Decrement producing 0000: DONE next cycle, `mag_on`=0, `timer_done`=1 in that same cycle.
  - `R`=1: PAUSED, `mag_on`=0, time and prescaler retained.
  - `R` wins over a simultaneous tick; no decrement occurs.
- PAUSED:
  - `digit_valid` is ignored.
  - `S`=1, `R`=0: RUNNING. Prescaler resumes from its retained value, so partial seconds are not lost.
- DONE:
  - `timer_done` stays 1; `S` and `R` are ignored.
  - Exit on `clear`, or on `digit_valid` with a legal digit: digits := 000d, state := IDLE, `timer_done`=0.
- `S` and `R` high together: `R` wins; no transition into RUNNING.
- Reset mid-RUNNING: `mag_on` drops asynchronously.

Optional Feature:
- Macro: COOK_TIMER_BEEP_EN.
- Defined:
  - On entry to DONE, `beep`=1 for BEEP_SECS × TICKS_PER_SEC cycles, timed with the prescaler, then 0.
  - `clear` or leaving DONE forces `beep`=0 immediately.
- Undefined: `beep` is tied to 0 and no beep counter is synthesized.

Decomposition:
- Package microwave_pkg:
  - state enum (IDLE, RUNNING, PAUSED, DONE)
  - 4-bit BCD digit typedef
  - packed MM:SS time struct
- One sub-module, bcd_time_dec: combinational MM:SS decrement with borrow, plus a zero-detect output, instantiated by cook_timer.

Test Plan (TICKS_PER_SEC=4):
- Entry: digits 1,3,0 then S=1 -> display 01:30, `mag_on`=1 next cycle; after 4 cycles -> 01:29.
- Borrow: entered 1,0,0 and run -> 01:00 then 00:59 one tick later. Entered 7,5 -> 00:75 then 00:74, …, 00:70, 00:69.
- Completion: entered 2 and run -> 00:01, 00:00 with `timer_done`=1 and `mag_on`=0 in the same cycle; further S/R cause no change; `digit_valid` 5 -> IDLE, 00:05, `timer_done`=0.
- Pause/resume:
  - Run 00:10, assert R at prescaler=2 -> PAUSED at 00:10.
  - S -> RUNNING; next decrement after 2 more cycles.
  - S and R together -> stays PAUSED.
- Illegal/idle inputs: S with 00:00 -> stays IDLE, `mag_on`=0; digit 4'hC -> ignored.
- Reset/clear:
  - `rst` pulse mid-RUNNING -> all outputs 0 asynchronously.
  - `clear` during RUNNING -> 00:00, IDLE, `mag_on`=0.
  - With COOK_TIMER_BEEP_EN: `beep` high exactly 12 cycles after DONE.
